// File: rtl/if_stage.sv
// Instruction fetch stage: keeps up to two fetches outstanding and buffers returned words in a
// two-entry FIFO. After a redirect it drops the responses of fetches that are still in flight.
package my_pkg;
  parameter int DATA_WIDTH = 32;
endpackage

module if_stage #(
  parameter int                    DATA_WIDTH = my_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [DATA_WIDTH-1:0] id_inst,
  output logic [DATA_WIDTH-1:0] id_pc
);

  localparam logic [DATA_WIDTH-1:0] PC_STEP = {{(DATA_WIDTH-3){1'b0}}, 3'd4};

  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] ifq_pc_q [2];
  logic [DATA_WIDTH-1:0] ifq_pc_d [2];
  logic [1:0]            ifq_cnt_q, ifq_cnt_d, ifq_cnt_tmp;
  logic [DATA_WIDTH-1:0] of_pc_q [2];
  logic [DATA_WIDTH-1:0] of_pc_d [2];
  logic [DATA_WIDTH-1:0] of_inst_q [2];
  logic [DATA_WIDTH-1:0] of_inst_d [2];
  logic [1:0]            of_cnt_q, of_cnt_d, of_cnt_tmp;
  logic [1:0]            drop_q, drop_d;

  logic req_fire, rsp_fire, rsp_keep, id_pop;
  logic [1:0] unused_redirect_lsbs;

  assign unused_redirect_lsbs = redirect_pc[1:0];

  // Credit check uses registered occupancy, so a FIFO slot freed this cycle is reused next cycle.
  assign imem_req_valid = rst_n && (({1'b0, of_cnt_q} + {1'b0, ifq_cnt_q}) < 3'd2)
                          && (drop_q == 2'd0) && !redirect_valid;
  assign imem_addr      = fetch_pc_q;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_fire = imem_rsp_valid && (ifq_cnt_q != 2'd0);
  assign rsp_keep = rsp_fire && (drop_q == 2'd0) && !redirect_valid;
  assign id_pop   = id_valid && id_ready && !redirect_valid;

  assign id_valid = (of_cnt_q != 2'd0);
  assign id_pc    = of_pc_q[0];
  assign id_inst  = of_inst_q[0];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
    end else if (req_fire) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end
  end

  // In-flight PCs keep draining on responses even across a redirect; only their data is dropped.
  always_comb begin
    ifq_pc_d    = ifq_pc_q;
    ifq_cnt_tmp = ifq_cnt_q;
    if (rsp_fire) begin
      ifq_pc_d[0] = ifq_pc_q[1];
      ifq_cnt_tmp = ifq_cnt_q - 2'd1;
    end
    if (req_fire) begin
      if (ifq_cnt_tmp == 2'd0) ifq_pc_d[0] = fetch_pc_q;
      else                     ifq_pc_d[1] = fetch_pc_q;
      ifq_cnt_tmp = ifq_cnt_tmp + 2'd1;
    end
    ifq_cnt_d = ifq_cnt_tmp;
  end

  always_comb begin
    drop_d = drop_q;
    if (redirect_valid) begin
      drop_d = ifq_cnt_d;
    end else if (rsp_fire && (drop_q != 2'd0)) begin
      drop_d = drop_q - 2'd1;
    end
  end

  always_comb begin
    of_pc_d    = of_pc_q;
    of_inst_d  = of_inst_q;
    of_cnt_tmp = of_cnt_q;
    if (id_pop) begin
      of_pc_d[0]   = of_pc_q[1];
      of_inst_d[0] = of_inst_q[1];
      of_cnt_tmp   = of_cnt_q - 2'd1;
    end
    if (rsp_keep) begin
      if (of_cnt_tmp == 2'd0) begin
        of_pc_d[0]   = ifq_pc_q[0];
        of_inst_d[0] = imem_rdata;
      end else begin
        of_pc_d[1]   = ifq_pc_q[0];
        of_inst_d[1] = imem_rdata;
      end
      of_cnt_tmp = of_cnt_tmp + 2'd1;
    end
    of_cnt_d = redirect_valid ? 2'd0 : of_cnt_tmp;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      ifq_cnt_q  <= 2'd0;
      of_cnt_q   <= 2'd0;
      drop_q     <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        ifq_pc_q[i]  <= '0;
        of_pc_q[i]   <= '0;
        of_inst_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      ifq_cnt_q  <= ifq_cnt_d;
      of_cnt_q   <= of_cnt_d;
      drop_q     <= drop_d;
      ifq_pc_q   <= ifq_pc_d;
      of_pc_q    <= of_pc_d;
      of_inst_q  <= of_inst_d;
    end
  end

endmodule
